sram_req_arbiter: RTL and testbench

Two-master, one-slave arbiter for the SRAM-like request/response bus. It merges the CPU core's instruction-fetch port and data-access port onto the single memory port that feeds the AXI bridge. Data requests take priority over instruction requests, and a granted request stays locked until its address handshake completes. An in-order owner FIFO routes each returned response to the master that issued it.

---
 rtl/sram_req_arbiter_if.sv | 30 +++
 rtl/sram_req_arbiter.sv | 116 +++++++++++
 tb/tb_sram_req_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_if
// One SRAM-like request/response bus.
//   Request  (master -> slave): req, wr, size[1:0], wstrb[3:0], addr[31:0],
//                               wdata[31:0]
//   Response (slave -> master): addr_ok, data_ok, rdata[31:0]
// The master modport is the side that issues requests; the slave modport is
// the side that accepts them and returns responses.
// ---------------------------------------------------------------------------
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Merges the instruction-fetch and data-access SRAM-like ports onto one
// memory port. Data requests win over instruction requests; a presented
// request that is not accepted is locked until its address handshake. An
// in-order owner FIFO steers each response back to the issuing master.
// Ports:
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   inst_bus  instruction master (slave modport: arbiter accepts requests)
//   data_bus  data master        (slave modport)
//   mem_bus   memory port        (master modport: arbiter issues requests)
// Parameter OUTSTANDING: max accepted-but-unanswered requests (power of 2, >=2)
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  sram_req_arbiter_if.slave        inst_bus,
  sram_req_arbiter_if.slave        data_bus,
  sram_req_arbiter_if.master       mem_bus
);

  localparam int              PW       = $clog2(OUTSTANDING);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(OUTSTANDING);

  logic                   lock_vld_q, lock_vld_d;
  logic                   lock_sel_q, lock_sel_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [PW:0]            cnt_q, cnt_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;

  logic sel;     // 1 = data master, 0 = instruction master
  logic full;
  logic hs;
  logic pop;
  logic head;

  // Grant: a held lock overrides priority so a presented request is never
  // swapped for another before it is accepted.
  assign sel  = lock_vld_q ? lock_sel_q : data_bus.req;

  // Full looks only at the registered count; a pop this cycle frees the
  // slot for the next cycle, keeping mem_data_ok off the mem_req path.
  assign full = (cnt_q == FULL_CNT);

  assign mem_bus.req   = !full && (lock_vld_q || data_bus.req || inst_bus.req);
  assign mem_bus.wr    = sel ? data_bus.wr    : inst_bus.wr;
  assign mem_bus.size  = sel ? data_bus.size  : inst_bus.size;
  assign mem_bus.wstrb = sel ? data_bus.wstrb : inst_bus.wstrb;
  assign mem_bus.addr  = sel ? data_bus.addr  : inst_bus.addr;
  assign mem_bus.wdata = sel ? data_bus.wdata : inst_bus.wdata;

  assign hs  = mem_bus.req && mem_bus.addr_ok;
  // Responses while nothing is outstanding are dropped.
  assign pop = mem_bus.data_ok && (cnt_q != '0);

  assign data_bus.addr_ok = hs && sel;
  assign inst_bus.addr_ok = hs && !sel;

  assign head = owner_q[rptr_q];

  assign data_bus.data_ok = pop && head;
  assign inst_bus.data_ok = pop && !head;
  assign data_bus.rdata   = mem_bus.rdata;
  assign inst_bus.rdata   = mem_bus.rdata;

  // Lock is taken the first cycle a request is shown without acceptance.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_sel_d = lock_sel_q;
    if (hs) begin
      lock_vld_d = 1'b0;
    end else if (mem_bus.req && !lock_vld_q) begin
      lock_vld_d = 1'b1;
      lock_sel_d = sel;
    end
  end

  // Pointers wrap naturally since OUTSTANDING is a power of 2.
  always_comb begin
    wptr_d = hs  ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_owner
    assign owner_d[gi] = (hs && (wptr_q == PW'(gi))) ? sel : owner_q[gi];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q <= 1'b0;
      lock_sel_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      owner_q    <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_sel_q <= lock_sel_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Directed bench for sram_req_arbiter (OUTSTANDING = 4). Inputs change 1 ns
// after each rising edge and outputs are checked 1 ns later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;

  logic clk;
  logic resetn;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if mem_if ();

  sram_req_arbiter #(.OUTSTANDING(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .mem_bus  (mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr, input logic wr);
    inst_if.req   = req;
    inst_if.addr  = addr;
    inst_if.wr    = wr;
    inst_if.size  = req ? 2'd2 : 2'd0;
    inst_if.wstrb = (req && wr) ? 4'hF : 4'h0;
    inst_if.wdata = (req && wr) ? 32'h1111_0000 : 32'h0;
  endtask

  task automatic set_data(input logic req, input logic [31:0] addr, input logic wr);
    data_if.req   = req;
    data_if.addr  = addr;
    data_if.wr    = wr;
    data_if.size  = req ? 2'd2 : 2'd0;
    data_if.wstrb = (req && wr) ? 4'h3 : 4'h0;
    data_if.wdata = (req && wr) ? 32'h2222_0000 : 32'h0;
  endtask

  task automatic set_mem(input logic addr_ok, input logic data_ok, input logic [31:0] rdata);
    mem_if.addr_ok = addr_ok;
    mem_if.data_ok = data_ok;
    mem_if.rdata   = rdata;
  endtask

  task automatic idle_all();
    set_inst(1'b0, 32'h0, 1'b0);
    set_data(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b0, 32'h0);
  endtask

  // Check a response cycle: which master sees data_ok and the data value.
  task automatic check_resp(input string tag, input logic exp_inst, input logic exp_data,
                            input logic [31:0] exp_rdata);
    check_eq({tag, " inst_data_ok"}, 32'(inst_if.data_ok), 32'(exp_inst));
    check_eq({tag, " data_data_ok"}, 32'(data_if.data_ok), 32'(exp_data));
    if (exp_inst) check_eq({tag, " inst_rdata"}, inst_if.rdata, exp_rdata);
    if (exp_data) check_eq({tag, " data_rdata"}, data_if.rdata, exp_rdata);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    idle_all();

    // ---------------- reset state ----------------
    #3;
    check_eq("rst mem_req", 32'(mem_if.req), 32'd0);
    check_eq("rst mem_addr", mem_if.addr, 32'd0);
    check_eq("rst inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    check_eq("rst data_data_ok", 32'(data_if.data_ok), 32'd0);
    check_eq("rst cnt", 32'(dut.cnt_q), 32'd0);
    #9 resetn = 1'b1;   // released at t=12, between edges
    tick();

    // ---------------- priority ----------------
    set_inst(1'b1, 32'h1C00_0000, 1'b0);
    set_data(1'b1, 32'h8000_0010, 1'b1);
    set_mem(1'b1, 1'b0, 32'h0);
    settle();
    check_eq("prio mem_addr", mem_if.addr, 32'h8000_0010);
    check_eq("prio mem_wr", 32'(mem_if.wr), 32'd1);
    check_eq("prio mem_wstrb", 32'(mem_if.wstrb), 32'h3);
    check_eq("prio data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    check_eq("prio inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    tick();
    set_data(1'b0, 32'h0, 1'b0);
    settle();
    check_eq("prio2 mem_addr", mem_if.addr, 32'h1C00_0000);
    check_eq("prio2 inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    check_eq("prio2 data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    set_inst(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b1, 32'h0000_0011);
    settle();
    check_resp("prio rsp0", 1'b0, 1'b1, 32'h0000_0011);
    tick();
    set_mem(1'b0, 1'b1, 32'h0000_0022);
    settle();
    check_resp("prio rsp1", 1'b1, 1'b0, 32'h0000_0022);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    settle();
    check_eq("prio cnt", 32'(dut.cnt_q), 32'd0);

    // ---------------- lock ----------------
    set_inst(1'b1, 32'h1C00_0100, 1'b0);
    settle();
    check_eq("lock c1 mem_req", 32'(mem_if.req), 32'd1);
    check_eq("lock c1 mem_addr", mem_if.addr, 32'h1C00_0100);
    tick();
    set_data(1'b1, 32'h8000_0020, 1'b1);
    settle();
    check_eq("lock c2 mem_addr", mem_if.addr, 32'h1C00_0100);
    check_eq("lock c2 mem_wr", 32'(mem_if.wr), 32'd0);
    tick();
    settle();
    check_eq("lock c3 mem_addr", mem_if.addr, 32'h1C00_0100);
    tick();
    set_mem(1'b1, 1'b0, 32'h0);
    settle();
    check_eq("lock c4 mem_addr", mem_if.addr, 32'h1C00_0100);
    check_eq("lock c4 inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    check_eq("lock c4 data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    set_inst(1'b0, 32'h0, 1'b0);
    settle();
    check_eq("lock c5 mem_addr", mem_if.addr, 32'h8000_0020);
    check_eq("lock c5 data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    tick();
    set_data(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b1, 32'h0000_0033);
    settle();
    check_resp("lock rsp0", 1'b1, 1'b0, 32'h0000_0033);
    tick();
    set_mem(1'b0, 1'b1, 32'h0000_0044);
    settle();
    check_resp("lock rsp1", 1'b0, 1'b1, 32'h0000_0044);
    tick();

    // ---------------- routing ----------------
    set_mem(1'b1, 1'b0, 32'h0);
    set_inst(1'b1, 32'h1C00_0000, 1'b0);
    settle();
    check_eq("route acc0 inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    tick();
    set_inst(1'b0, 32'h0, 1'b0);
    set_data(1'b1, 32'h8000_0010, 1'b0);
    settle();
    check_eq("route acc1 data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    tick();
    set_data(1'b0, 32'h0, 1'b0);
    set_inst(1'b1, 32'h1C00_0004, 1'b0);
    settle();
    check_eq("route acc2 mem_addr", mem_if.addr, 32'h1C00_0004);
    tick();
    set_inst(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b1, 32'h0000_000A);
    settle();
    check_resp("route rsp0", 1'b1, 1'b0, 32'h0000_000A);
    tick();
    set_mem(1'b0, 1'b1, 32'h0000_000B);
    settle();
    check_resp("route rsp1", 1'b0, 1'b1, 32'h0000_000B);
    tick();
    set_mem(1'b0, 1'b1, 32'h0000_000C);
    settle();
    check_resp("route rsp2", 1'b1, 1'b0, 32'h0000_000C);
    tick();
    // Spurious response with nothing outstanding.
    set_mem(1'b0, 1'b1, 32'h0000_00EE);
    settle();
    check_eq("route cnt", 32'(dut.cnt_q), 32'd0);
    check_resp("spurious", 1'b0, 1'b0, 32'h0);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    settle();
    check_eq("spurious cnt", 32'(dut.cnt_q), 32'd0);

    // ---------------- full ----------------
    set_mem(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_inst(1'b1, 32'h1C00_1000 + 32'(i * 4), 1'b0);
      settle();
      check_eq($sformatf("full acc%0d inst_addr_ok", i), 32'(inst_if.addr_ok), 32'd1);
      tick();
    end
    set_inst(1'b1, 32'h1C00_1010, 1'b0);
    settle();
    check_eq("full 5th mem_req", 32'(mem_if.req), 32'd0);
    check_eq("full 5th inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    tick();
    set_mem(1'b1, 1'b1, 32'h0000_0055);
    settle();
    check_eq("full pop mem_req", 32'(mem_if.req), 32'd0);
    check_resp("full pop", 1'b1, 1'b0, 32'h0000_0055);
    tick();
    set_mem(1'b1, 1'b0, 32'h0);
    settle();
    check_eq("full reassert mem_req", 32'(mem_if.req), 32'd1);
    check_eq("full reassert inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    tick();
    set_inst(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b1, 32'h0000_0066);
    settle();
    check_eq("full cnt", 32'(dut.cnt_q), 32'd4);
    tick();
    settle();
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    settle();
    check_eq("drain cnt", 32'(dut.cnt_q), 32'd2);

    // ------- simultaneous push/pop across the pointer wrap -------
    // Remaining entries are instruction-owned; push data, data, inst.
    set_mem(1'b1, 1'b1, 32'h0000_0071);
    set_data(1'b1, 32'h8000_0100, 1'b0);
    settle();
    check_eq("pp0 data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    check_resp("pp0", 1'b1, 1'b0, 32'h0000_0071);
    tick();
    check_eq("pp0 cnt", 32'(dut.cnt_q), 32'd2);
    set_mem(1'b1, 1'b1, 32'h0000_0072);
    set_data(1'b1, 32'h8000_0104, 1'b0);
    settle();
    check_resp("pp1", 1'b1, 1'b0, 32'h0000_0072);
    tick();
    check_eq("pp1 cnt", 32'(dut.cnt_q), 32'd2);
    set_data(1'b0, 32'h0, 1'b0);
    set_inst(1'b1, 32'h1C00_2000, 1'b0);
    set_mem(1'b1, 1'b1, 32'h0000_0073);
    settle();
    check_eq("pp2 inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    check_resp("pp2", 1'b0, 1'b1, 32'h0000_0073);
    tick();
    check_eq("pp2 cnt", 32'(dut.cnt_q), 32'd2);
    set_inst(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b1, 32'h0000_0074);
    settle();
    check_resp("pp drain0", 1'b0, 1'b1, 32'h0000_0074);
    tick();
    set_mem(1'b0, 1'b1, 32'h0000_0075);
    settle();
    check_resp("pp drain1", 1'b1, 1'b0, 32'h0000_0075);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);

    // ---------------- reset mid-operation ----------------
    set_mem(1'b1, 1'b0, 32'h0);
    set_inst(1'b1, 32'h1C00_3000, 1'b0);
    tick();
    tick();
    tick();
    set_inst(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b0, 32'h0);
    set_data(1'b1, 32'h8000_0200, 1'b1);
    tick();
    check_eq("mid cnt before", 32'(dut.cnt_q), 32'd3);
    check_eq("mid lock before", 32'(dut.lock_vld_q), 32'd1);
    #1 resetn = 1'b0;   // asynchronous, mid-cycle
    #1;
    check_eq("mid cnt after rst", 32'(dut.cnt_q), 32'd0);
    check_eq("mid lock after rst", 32'(dut.lock_vld_q), 32'd0);
    set_data(1'b0, 32'h0, 1'b0);
    #1;
    check_eq("mid rst mem_req idle", 32'(mem_if.req), 32'd0);
    tick();
    resetn = 1'b1;
    set_inst(1'b1, 32'h1C00_4000, 1'b0);
    settle();
    check_eq("post rst mem_req", 32'(mem_if.req), 32'd1);
    check_eq("post rst mem_addr", mem_if.addr, 32'h1C00_4000);
    set_inst(1'b0, 32'h0, 1'b0);
    set_mem(1'b0, 1'b1, 32'h0000_0099);
    settle();
    check_eq("post rst mem_req off", 32'(mem_if.req), 32'd0);
    check_resp("post rst spurious", 1'b0, 1'b0, 32'h0);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
